// File: rtl/crank_gen_pkg.sv
// Purpose: shared types and constants for the crank/cam trigger-wheel generator.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package crank_gen_pkg;

  localparam int MIN_PERIOD   = 3;
  localparam int CFG_PRESC_W  = 8;
  localparam int CFG_PERIOD_W = 16;
  localparam int CFG_TOOTH_W  = 8;

  typedef enum logic [1:0] {
    CAM_OFF   = 2'd0,
    CAM_EVERY = 2'd1,
    CAM_PH0   = 2'd2,
    CAM_PH1   = 2'd3
  } cam_mode_t;

  // Crank-side configuration held in the pending and active shadow sets.
  // Field widths track the default PRESC_W/PERIOD_W/TOOTH_W of the top.
  typedef struct packed {
    logic [CFG_PRESC_W-1:0]  presc;
    logic [CFG_PERIOD_W-1:0] period;
    logic [CFG_TOOTH_W-1:0]  teeth;
    logic [1:0]              missing;
    logic [CFG_PERIOD_W-1:0] target;
    logic [CFG_PERIOD_W-1:0] step;
  } crank_cfg_t;

  // Shorter tooth periods leave no room for a distinct high/low phase.
  function automatic logic [CFG_PERIOD_W-1:0] clamp_period(input logic [CFG_PERIOD_W-1:0] v);
    return (v < CFG_PERIOD_W'(MIN_PERIOD)) ? CFG_PERIOD_W'(MIN_PERIOD) : v;
  endfunction

endpackage

// File: rtl/crank_cam_chan.sv
// Purpose: one cam channel, placed by tooth index and gated by engine phase.
// Latency: output updates on the same clk edge as the end-of-tooth it reacts to.
// Backpressure: none; only advances on end-of-tooth, so it freezes with the wheel.
module crank_cam_chan
  import crank_gen_pkg::*;
#(
  parameter int TOOTH_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               eot,
  input  logic [TOOTH_W-1:0] new_idx,
  input  logic               new_phase,
  input  cam_mode_t          mode,
  input  logic [TOOTH_W-1:0] rise,
  input  logic [TOOTH_W-1:0] fall,
  output logic               cam
);

  logic qualifies;

  // Channel is live in this revolution only if its mode matches the new phase.
  always_comb begin
    qualifies = 1'b0;
    case (mode)
      CAM_EVERY: qualifies = 1'b1;
      CAM_PH0:   qualifies = ~new_phase;
      CAM_PH1:   qualifies = new_phase;
      default:   qualifies = 1'b0;
    endcase
  end

  // Edge placement on tooth boundaries; fall is checked first so it wins a tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cam <= 1'b0;
    end else if (eot) begin
      if (!qualifies)
        cam <= 1'b0;
      else if (new_idx == fall)
        cam <= 1'b0;
      else if (new_idx == rise)
        cam <= 1'b1;
    end
  end

endmodule

// File: rtl/crank_cam_gen.sv
// Purpose: crank tooth wheel (missing-tooth gap) plus CAM_N cam channels; speed ramp under CRANK_CAM_GEN_RAMP_EN.
// Latency: all outputs registered; they change on the clk of the qualifying prescaler tick.
// Backpressure: en low freezes counters and outputs; cfg_load is held pending until rev wrap or idle.
module crank_cam_gen
  import crank_gen_pkg::*;
#(
  parameter int PRESC_W  = 8,
  parameter int PERIOD_W = 16,
  parameter int TOOTH_W  = 8,
  parameter int CAM_N    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [PRESC_W-1:0]       cfg_presc,
  input  logic [PERIOD_W-1:0]      cfg_period,
  input  logic [TOOTH_W-1:0]       cfg_teeth,
  input  logic [1:0]               cfg_missing,
  input  logic [2*CAM_N-1:0]       cfg_cam_mode,
  input  logic [TOOTH_W*CAM_N-1:0] cfg_cam_rise,
  input  logic [TOOTH_W*CAM_N-1:0] cfg_cam_fall,
  input  logic [PERIOD_W-1:0]      cfg_target,
  input  logic [PERIOD_W-1:0]      cfg_step,
  input  logic                     cfg_load,
  output logic                     vr_out,
  output logic [CAM_N-1:0]         cam_out,
  output logic [TOOTH_W-1:0]       tooth_idx,
  output logic                     phase,
  output logic                     rev_strobe,
  output logic                     ramp_done
);

  // Tick counter is two bits wider so the gap tooth (up to 4x) fits.
  localparam int TW = PERIOD_W + 2;

  crank_cfg_t               sh_cfg, pd_cfg;
  logic                     pending;
  logic [2*CAM_N-1:0]       sh_mode, pd_mode, mode_use;
  logic [TOOTH_W*CAM_N-1:0] sh_rise, pd_rise, rise_use;
  logic [TOOTH_W*CAM_N-1:0] sh_fall, pd_fall, fall_use;

  logic [PRESC_W-1:0]  p;
  logic [TW-1:0]       t;
  logic [PERIOD_W-1:0] period_eff;
  logic [TW-1:0]       pp1, gap_top, top;
  logic                tick, last, eot, wrap, apply;
  logic [TOOTH_W-1:0]  idx_nxt;

  // Comparisons use >= so a shadow update that shrinks a limit mid-tooth cannot strand a counter.
  assign tick    = en && (p >= sh_cfg.presc);
  assign last    = (tooth_idx >= sh_cfg.teeth);
  assign eot     = tick && (t >= top);
  assign wrap    = eot && last;
  assign apply   = pending && (wrap || !en);
  assign idx_nxt = last ? '0 : tooth_idx + TOOTH_W'(1);

  // On a wrap that applies new config, cams see the values of the revolution being entered.
  assign mode_use = apply ? pd_mode : sh_mode;
  assign rise_use = apply ? pd_rise : sh_rise;
  assign fall_use = apply ? pd_fall : sh_fall;

`ifdef CRANK_CAM_GEN_RAMP_EN
  logic [PERIOD_W-1:0] period_act, period_act_d, base, tgt_d, stp;
  logic                unused_cfg;

  assign period_eff = period_act;
  assign unused_cfg = ^sh_cfg.period;

  // New shadow values take effect first, then a wrap moves the period one step toward target.
  always_comb begin
    base         = apply ? clamp_period(pd_cfg.period) : period_act;
    tgt_d        = apply ? clamp_period(pd_cfg.target) : clamp_period(sh_cfg.target);
    stp          = apply ? pd_cfg.step : sh_cfg.step;
    period_act_d = base;
    if (wrap) begin
      if (base > tgt_d)
        period_act_d = ((base - tgt_d) > stp) ? base - stp : tgt_d;
      else if (base < tgt_d)
        period_act_d = ((tgt_d - base) > stp) ? base + stp : tgt_d;
    end
  end

  // Active period register and its done flag, kept in step with each other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_act <= PERIOD_W'(MIN_PERIOD);
      ramp_done  <= 1'b0;
    end else begin
      period_act <= period_act_d;
      ramp_done  <= (period_act_d == tgt_d);
    end
  end
`else
  logic unused_cfg;

  assign period_eff = clamp_period(sh_cfg.period);
  assign unused_cfg = ^{sh_cfg.target, sh_cfg.step};

  // Without the ramp the period is always at its target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ramp_done <= 1'b0;
    else     ramp_done <= 1'b1;
  end
`endif

  // Tooth top: the last real tooth absorbs the missing ones, (period+1)*(missing+1)-1 ticks.
  always_comb begin
    pp1 = TW'(period_eff) + TW'(1);
    case (sh_cfg.missing)
      2'd0:    gap_top = pp1;
      2'd1:    gap_top = pp1 << 1;
      2'd2:    gap_top = (pp1 << 1) + pp1;
      default: gap_top = pp1 << 2;
    endcase
    gap_top = gap_top - TW'(1);
    top     = last ? gap_top : TW'(period_eff);
  end

  // Pending/active config sets; a load in the same clk as an apply is kept for the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_cfg  <= '0;
      pd_cfg  <= '0;
      sh_mode <= '0;
      pd_mode <= '0;
      sh_rise <= '0;
      pd_rise <= '0;
      sh_fall <= '0;
      pd_fall <= '0;
      pending <= 1'b0;
    end else begin
      if (apply) begin
        sh_cfg  <= pd_cfg;
        sh_mode <= pd_mode;
        sh_rise <= pd_rise;
        sh_fall <= pd_fall;
        pending <= 1'b0;
      end
      if (cfg_load) begin
        pd_cfg  <= '{presc: cfg_presc, period: cfg_period, teeth: cfg_teeth,
                     missing: cfg_missing, target: cfg_target, step: cfg_step};
        pd_mode <= cfg_cam_mode;
        pd_rise <= cfg_cam_rise;
        pd_fall <= cfg_cam_fall;
        pending <= 1'b1;
      end
    end
  end

  // Wheel timing: prescaler, tick-in-tooth, tooth index, phase and VR edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p          <= '0;
      t          <= '0;
      tooth_idx  <= '0;
      phase      <= 1'b0;
      vr_out     <= 1'b0;
      rev_strobe <= 1'b0;
    end else begin
      rev_strobe <= wrap;
      if (en) begin
        if (tick) begin
          p <= '0;
          if (eot) begin
            t         <= '0;
            vr_out    <= 1'b0;
            tooth_idx <= idx_nxt;
            if (last) phase <= ~phase;
          end else begin
            t <= t + TW'(1);
            if (t == (top >> 1)) vr_out <= 1'b1;
          end
        end else begin
          p <= p + PRESC_W'(1);
        end
      end
    end
  end

  for (genvar c = 0; c < CAM_N; c++) begin : g_cam
    crank_cam_chan #(.TOOTH_W(TOOTH_W)) u_chan (
      .clk       (clk),
      .rst       (rst),
      .eot       (eot),
      .new_idx   (idx_nxt),
      .new_phase (phase ^ last),
      .mode      (cam_mode_t'(mode_use[2*c +: 2])),
      .rise      (rise_use[TOOTH_W*c +: TOOTH_W]),
      .fall      (fall_use[TOOTH_W*c +: TOOTH_W]),
      .cam       (cam_out[c])
    );
  end

endmodule

// File: doc/crank_cam_gen.md
# crank_cam_gen

Synthesizable crank/cam trigger-wheel generator for closed-loop testing of the hardware angle generator (hwag) without an engine. It produces a VR-style crank tooth signal with a configurable missing-tooth gap, plus CAM_N cam channels placed by tooth index and engine phase. An optional linear speed ramp sweeps tooth period across revolutions. It sits beside hwag, driving its `vr_in` and cam inputs on-chip or from a test harness.

## Interface
- `PRESC_W`, 8, prescaler width
- `PERIOD_W`, 16, tooth-period counter width
- `TOOTH_W`, 8, tooth-index width
- `CAM_N`, 2, number of cam channels
- `clk` in 1: system clock
- `rst` in 1: reset, asynchronous, active-high
- `en` in 1: run; low freezes all counters and outputs
- `cfg_presc` in PRESC_W: tick every cfg_presc+1 clk
- `cfg_period` in PERIOD_W: normal tooth length in ticks minus 1; values <3 clamp to 3
- `cfg_teeth` in TOOTH_W: index of last real tooth; 57 for 60-2
- `cfg_missing` in 2: missing teeth, 0..3
- `cfg_cam_mode` in 2*CAM_N: per channel 0=off, 1=every rev, 2=phase 0 only, 3=phase 1 only
- `cfg_cam_rise`, `cfg_cam_fall` in TOOTH_W*CAM_N: tooth index of rise and fall
- `cfg_target` in PERIOD_W, `cfg_step` in PERIOD_W: ramp target and per-revolution step
- `cfg_load` in 1: one-clk request to latch all cfg_* into the shadow set
- `vr_out` out 1: crank tooth signal
- `cam_out` out CAM_N: cam signals
- `tooth_idx` out TOOTH_W: current tooth
- `phase` out 1: engine phase, toggles each revolution
- `rev_strobe` out 1: one-clk pulse at revolution wrap
- `ramp_done` out 1: active period equals target

## Operation
- Reset: p=0, t=0, tooth_idx=0, phase=0, vr_out=0, cam_out=0, rev_strobe=0, ramp_done=0. Shadow config = 0, so period clamps to 3.
- Prescaler p counts 0..presc. A tick occurs on the clk where p==presc.
- Tooth top: period_act for tooth_idx<teeth. For tooth_idx==teeth, top is gap_top=(period_act+1)*(missing+1)-1, computed at PERIOD_W+2 bits.
- On a tick with t==top (end-of-tooth):
  - t<=0, vr_out<=0.
  - tooth_idx<=tooth_idx+1, or 0 if tooth_idx==teeth. The wrap also toggles phase and pulses rev_strobe.
- On any other tick: t<=t+1. If t==top>>1, vr_out<=1.
- Cam channel c, evaluated on end-of-tooth against the new tooth_idx and new phase, when its mode qualifies:
  - new idx==rise drives the channel high; new idx==fall drives it low. If rise==fall, fall wins.
  - mode 0 forces low.
  - A mode-2/3 channel is held low for the whole revolution in the non-matching phase.
- cfg_load sets a pending flag. Shadow update happens at the next rev wrap, or on the next clk if en=0. A second load before apply overwrites the pending values.
- en low mid-tooth: p, t, tooth_idx and all outputs hold. Resume continues from the same p.

## Timing
- All outputs are registered. vr_out and cam_out change on the clk of the qualifying tick.
- rev_strobe is high for exactly 1 clk, coincident with tooth_idx becoming 0.
- Normal tooth = (presc+1)(period+1) clk. vr_out is high for (period+1)-((period>>1)+1) ticks.
- Simultaneous rev wrap, pending shadow apply and ramp step: the new revolution uses the new shadow values, then the ramp step is applied.

## Configuration
- Macro `CRANK_CAM_GEN_RAMP_EN` defined: on each rev wrap, period_act moves toward cfg_target by cfg_step.
  - It saturates at the target and never overshoots. step=0 holds the period.
  - ramp_done=1 when period_act==target.
- Macro undefined: period_act = shadow cfg_period, cfg_target and cfg_step are ignored, and ramp_done is tied 1.

## Structure
- Package `crank_gen_pkg`: `cam_mode_t` enum (CAM_OFF, CAM_EVERY, CAM_PH0, CAM_PH1), MIN_PERIOD=3 constant, config shadow struct.
- Sub-module `crank_cam_chan`, one instance per cam channel. Inputs: end-of-tooth, new idx, new phase, mode, rise, fall. Output: registered cam bit.

## Test plan
- presc=3, period=63, teeth=57, missing=2, en=1 -> normal tooth 256 clk with vr high 128 clk; gap tooth 768 clk; rev_strobe every 15360 clk.
- Cam0 mode=3, rise=4, fall=54 -> cam0 rises as idx becomes 4 and falls as idx becomes 54, in phase-1 revolutions only; stays 0 throughout phase-0 revolutions.
- cfg_load with period=31 at tooth 20 -> tooth lengths stay 256 clk until rev_strobe, then 128 clk from tooth 0.
- en low for 1000 clk mid-tooth -> tooth_idx, vr_out and cam_out unchanged; tooth completes with 1000 extra clk.
- RAMP_EN, period=63, target=31, step=8 -> successive revolutions use 55, 47, 39, 31, 31; ramp_done asserts at the 4th wrap.
- rst pulse mid-tooth with vr_out=1 -> vr_out, cam_out and tooth_idx are 0 before the next clk edge.
